// File: rtl/vga_sig_gen_if.sv
// VGA generator <-> frame-buffer/display bundle.
// Latency: n/a (wiring only).
// Backpressure: none; the scan is free-running and the buffer must answer in 1 clock.
//
// Signals:
//   config_colours  [15:8] foreground (buffer bit 1), [7:0] background (buffer bit 0)
//   vga_data        frame-buffer read data, valid 1 clock after vga_addr changes
//   vga_addr        frame-buffer read address {v[8:2], h[9:2]}
//   vga_hs/vga_vs   active-low syncs
//   vga_colour      RGB332 pixel
//   frame_start     one-clock pulse when the scan restarts at (0,0)
interface vga_sig_gen_if;
    logic [15:0] config_colours;
    logic        vga_data;
    logic [14:0] vga_addr;
    logic        vga_hs;
    logic        vga_vs;
    logic [7:0]  vga_colour;
    logic        frame_start;

    // Generator side.
    modport master (
        input  config_colours,
        input  vga_data,
        output vga_addr,
        output vga_hs,
        output vga_vs,
        output vga_colour,
        output frame_start
    );

    // Buffer / display side.
    modport slave (
        output config_colours,
        output vga_data,
        input  vga_addr,
        input  vga_hs,
        input  vga_vs,
        input  vga_colour,
        input  frame_start
    );
endinterface

// File: rtl/vga_sig_gen.sv
// 640x480@60Hz VGA timing generator scanning a 256x128 1-bit frame buffer (4x4 screen px per buffer px).
// Latency: syncs/colour lag the counters by one pixel (4 clocks); buffer read latency 1 clock.
// Backpressure: none; free-running scan at clk/4.
//
// Ports:
//   clk   system clock, shared with the frame-buffer read port
//   rst   asynchronous active-high reset
//   vga   vga_sig_gen_if.master: config_colours, vga_data in; vga_addr, syncs, colour, frame_start out
module vga_sig_gen #(
    parameter int unsigned H_VIS  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_VIS  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33
) (
    input  logic          clk,
    input  logic          rst,
    vga_sig_gen_if.master vga
);

    localparam int unsigned H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_VIS + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;   // exclusive
    localparam int unsigned VS_START = V_VIS + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;   // exclusive

    logic [1:0] div_cnt;
    logic       tick;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [9:0] h_nxt;
    logic [9:0] v_nxt;
    logic       h_wrap;
    logic       v_wrap;
    logic       in_hsync;
    logic       in_vsync;
    logic       visible;
    logic [7:0] colour_nxt;

    logic       hs_q;
    logic       vs_q;
    logic [7:0] colour_q;
    logic       frame_start_q;

    // Pixel enable: one clock in four, first one on the 4th clock after reset release.
    always_comb begin
        tick = (div_cnt == 2'd3);
    end

    always_comb begin
        h_wrap = (h_cnt == 10'(H_TOTAL - 1));
        v_wrap = (v_cnt == 10'(V_TOTAL - 1));
        h_nxt  = h_wrap ? 10'd0 : h_cnt + 10'd1;
        v_nxt  = v_cnt;
        if (h_wrap) begin
            v_nxt = v_wrap ? 10'd0 : v_cnt + 10'd1;
        end
    end

    // Output decode works on the counters as they stand before the advance, so syncs
    // and colour all carry the same one-pixel lag. vga_data for the current address has
    // had at least 3 clocks to arrive by the time tick samples it.
    always_comb begin
        in_hsync   = (h_cnt >= 10'(HS_START)) && (h_cnt < 10'(HS_END));
        in_vsync   = (v_cnt >= 10'(VS_START)) && (v_cnt < 10'(VS_END));
        visible    = (h_cnt < 10'(H_VIS)) && (v_cnt < 10'(V_VIS));
        colour_nxt = 8'd0;
        if (visible) begin
            colour_nxt = vga.vga_data ? vga.config_colours[15:8] : vga.config_colours[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= 2'd0;
            h_cnt   <= 10'd0;
            v_cnt   <= 10'd0;
        end else begin
            div_cnt <= div_cnt + 2'd1;
            if (tick) begin
                h_cnt <= h_nxt;
                v_cnt <= v_nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            colour_q      <= 8'd0;
            frame_start_q <= 1'b0;
        end else begin
            // Pulse follows the tick that takes the counters to (0,0).
            frame_start_q <= tick && h_wrap && v_wrap;
            if (tick) begin
                hs_q     <= ~in_hsync;
                vs_q     <= ~in_vsync;
                colour_q <= colour_nxt;
            end
        end
    end

    // Rows and columns beyond the 160x120 visible window map to unused buffer
    // locations; blanking masks whatever comes back.
    assign vga.vga_addr    = {v_cnt[8:2], h_cnt[9:2]};
    assign vga.vga_hs      = hs_q;
    assign vga.vga_vs      = vs_q;
    assign vga.vga_colour  = colour_q;
    assign vga.frame_start = frame_start_q;

endmodule
